// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame constants and the baud divisor helper.
package uart_pkg;

  localparam int DATA_BITS      = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Floor divide; a divisor below 1 would never tick, so it is held at 1.
  function automatic int calc_tick_div(input int clk_freq, input int baud, input int os);
    int d;
    d = clk_freq / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample enable generator: one-clk tick every DIV clocks, phase reset by clr_i.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver, link partner of uart_tx.
// Define UART_RX_PARITY_EN for an even-parity bit after the data and an rx_parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 125000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 rx_parity_err
`endif
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam int BW       = $clog2(DATA_BITS);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 s1_q, s2_q, rxs;
  logic [1:0]           warm_q;
  logic                 seen_hi_q, seen_hi_d;
  rx_state_e            state_q, state_d;
  logic [SW-1:0]        samp_q, samp_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 tick, tick_clr;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  assign rxs = s2_q;

  // Synchroniser flops reset high, so they hold no real line history until
  // warm_q has seen two clocks; only then may a high level qualify start edges.
  assign seen_hi_d = seen_hi_q | (warm_q[1] & rxs);

  always_comb begin
    state_d  = state_q;
    samp_d   = samp_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    tick_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
    perr_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (seen_hi_q && !rxs) begin
          state_d  = ST_START;
          samp_d   = '0;
          tick_clr = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (samp_q == HALF_LAST) begin
            samp_d  = '0;
            bit_d   = '0;
            state_d = rxs ? ST_IDLE : ST_DATA;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (samp_q == FULL_LAST) begin
            samp_d  = '0;
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (samp_q == FULL_LAST) begin
            samp_d  = '0;
            par_d   = rxs;
            state_d = ST_STOP;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (samp_q == FULL_LAST) begin
            samp_d = '0;
            if (rxs) begin
              data_d  = shift_q;
              valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_d  = ^{shift_q, par_q};
`endif
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      // A held-low line must not be decoded as a stream of 0x00 frames.
      ST_BREAK: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      warm_q    <= '0;
      seen_hi_q <= 1'b0;
      state_q   <= ST_IDLE;
      samp_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      s1_q      <= rx;
      s2_q      <= s1_q;
      warm_q    <= {warm_q[0], 1'b1};
      seen_hi_q <= seen_hi_d;
      state_q   <= state_d;
      samp_q    <= samp_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = perr_q;
`endif

endmodule
